// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and constants for the direct-mapped data cache.
//               Address-field split (tag/index/word/byte), command encoding
//               and the command-priority decoder used by cache_mem and
//               cache_tag_ram.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  localparam int TAG_W    = 22;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 2;
  localparam int LINES    = 64;
  localparam int WORDS    = 4;

  // 32-bit byte address: tag[31:10] | index[9:4] | word[3:2] | byte[1:0]
  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] word;
    logic [1:0]          byte_sel;
  } addr_fields_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_STORE = 2'd1,
    CMD_EDIT  = 2'd2,
    CMD_INVAL = 2'd3
  } cmd_e;

  // Collapse the three command strobes into the single command that acts
  // this cycle: invalid beats edit, edit beats store.
  function automatic cmd_e decode_cmd(input logic store,
                                      input logic edit,
                                      input logic invalid);
    cmd_e cmd;
    cmd = CMD_NONE;
    if (invalid) begin
      cmd = CMD_INVAL;
    end else if (edit) begin
      cmd = CMD_EDIT;
    end else if (store) begin
      cmd = CMD_STORE;
    end
    return cmd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_tag_ram.sv
// ============================================================================
// Module      : cache_tag_ram
// Description : Per-line valid / dirty / tag storage plus hit comparator.
//               Lookup is combinational on index/tag_in; updates happen on
//               the rising clock edge according to the decoded command.
//               Dirty storage exists only when CACHE_DIRTY_EN is defined;
//               otherwise dirty is tied low.
// Ports       : clk     - clock
//               rst     - asynchronous active-low reset
//               cmd     - decoded command for this cycle
//               index   - line index
//               tag_in  - tag field of the current address
//               hit     - line valid and stored tag matches tag_in
//               valid   - valid bit of the indexed line
//               dirty   - dirty bit of the indexed line
//               tag     - stored tag of the indexed line
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_tag_ram
  import cache_pkg::*;
#(
  parameter int LINES = cache_pkg::LINES
) (
  input  logic               clk,
  input  logic               rst,
  input  cmd_e               cmd,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               hit,
  output logic               valid,
  output logic               dirty,
  output logic [TAG_W-1:0]   tag
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];

  // Invalidation keeps the tag so the line can still be inspected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int l = 0; l < LINES; l++) begin
        r_tag[l] <= '0;
      end
    end else begin
      case (cmd)
        CMD_INVAL: r_valid[index] <= 1'b0;
        CMD_STORE,
        CMD_EDIT: begin
          r_valid[index] <= 1'b1;
          r_tag[index]   <= tag_in;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_DIRTY_EN
  logic [LINES-1:0] r_dirty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dirty <= '0;
    end else begin
      case (cmd)
        CMD_INVAL,
        CMD_STORE: r_dirty[index] <= 1'b0;
        CMD_EDIT:  r_dirty[index] <= 1'b1;
        default: ;
      endcase
    end
  end

  assign dirty = r_dirty[index];
`else
  assign dirty = 1'b0;
`endif

  assign valid = r_valid[index];
  assign tag   = r_tag[index];
  assign hit   = r_valid[index] && (r_tag[index] == tag_in);

endmodule

`default_nettype wire

// File: rtl/cache_mem.sv
// ============================================================================
// Module      : cache_mem
// Description : Direct-mapped write-back data cache array, LINES lines of
//               WORDS x 32-bit words. Combinational lookup, synchronous
//               update (store = refill, edit = CPU write, invalid = flush).
//               Optional feature macro: CACHE_DIRTY_EN (dirty tracking).
// Ports       : clk     - clock, state updates on rising edge
//               rst     - asynchronous active-low reset
//               addr    - byte address (tag/index/word/byte)
//               store   - refill write of din, line valid and clean
//               edit    - CPU write of din, line valid and dirty
//               invalid - invalidate indexed line
//               din     - write data
//               hit     - indexed line valid with matching tag
//               dout    - stored word at (index, word), regardless of hit
//               valid   - valid bit of indexed line
//               dirty   - dirty bit of indexed line
//               tag     - stored tag of indexed line
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem
  import cache_pkg::*;
#(
  parameter int LINES = cache_pkg::LINES,
  parameter int WORDS = cache_pkg::WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic             store,
  input  logic             edit,
  input  logic             invalid,
  input  logic [31:0]      din,
  output logic             hit,
  output logic [31:0]      dout,
  output logic             valid,
  output logic             dirty,
  output logic [TAG_W-1:0] tag
);

  addr_fields_t w_fields;
  cmd_e         w_cmd;
  logic         w_unused_byte;

  logic [31:0] r_data [LINES][WORDS];

  assign w_fields      = addr_fields_t'(addr);
  assign w_cmd         = decode_cmd(store, edit, invalid);
  // Byte offset is irrelevant for word-granular storage.
  assign w_unused_byte = ^w_fields.byte_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < LINES; l++) begin
        for (int w = 0; w < WORDS; w++) begin
          r_data[l][w] <= '0;
        end
      end
    end else if (w_cmd == CMD_STORE || w_cmd == CMD_EDIT) begin
      r_data[w_fields.index][w_fields.word] <= din;
    end
  end

  // No write bypass: dout reflects the array contents before the edge.
  assign dout = r_data[w_fields.index][w_fields.word];

  cache_tag_ram #(
    .LINES (LINES)
  ) u_tag_ram (
    .clk    (clk),
    .rst    (rst),
    .cmd    (w_cmd),
    .index  (w_fields.index),
    .tag_in (w_fields.tag),
    .hit    (hit),
    .valid  (valid),
    .dirty  (dirty),
    .tag    (tag)
  );

endmodule

`default_nettype wire

// File: tb/tb_cache_mem.sv
// ============================================================================
// Module      : tb_cache_mem
// Description : Self-checking bench for cache_mem. Directed scenarios from
//               the cache usage model plus a randomized command stream
//               checked against an array-based reference model.
//               Honors CACHE_DIRTY_EN for the expected dirty behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_mem;

`ifdef CACHE_DIRTY_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        store;
  logic        edit;
  logic        invalid;
  logic [31:0] din;
  logic        hit;
  logic [31:0] dout;
  logic        valid;
  logic        dirty;
  logic [21:0] tag;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays indexed by line / word.
  logic [31:0] m_data  [64][4];
  logic        m_valid [64];
  logic        m_dirty [64];
  logic [21:0] m_tag   [64];

  always #5 clk = ~clk;

  cache_mem #(
    .LINES (64),
    .WORDS (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .store   (store),
    .edit    (edit),
    .invalid (invalid),
    .din     (din),
    .hit     (hit),
    .dout    (dout),
    .valid   (valid),
    .dirty   (dirty),
    .tag     (tag)
  );

  task automatic model_reset();
    for (int l = 0; l < 64; l++) begin
      m_valid[l] = 1'b0;
      m_dirty[l] = 1'b0;
      m_tag[l]   = '0;
      for (int w = 0; w < 4; w++) m_data[l][w] = '0;
    end
  endtask

  task automatic model_apply(input logic [31:0] a, input logic s, input logic e,
                             input logic inv, input logic [31:0] d);
    int l;
    int w;
    l = int'(a[9:4]);
    w = int'(a[3:2]);
    if (inv) begin
      m_valid[l] = 1'b0;
      m_dirty[l] = 1'b0;
    end else if (e || s) begin
      m_data[l][w] = d;
      m_tag[l]     = a[31:10];
      m_valid[l]   = 1'b1;
      m_dirty[l]   = e ? DIRTY_EN : 1'b0;
    end
  endtask

  task automatic model_read(input logic [31:0] a, output logic e_hit,
                            output logic [31:0] e_dout, output logic e_valid,
                            output logic e_dirty, output logic [21:0] e_tag);
    int l;
    l = int'(a[9:4]);
    e_valid = m_valid[l];
    e_dirty = m_dirty[l];
    e_tag   = m_tag[l];
    e_dout  = m_data[l][int'(a[3:2])];
    e_hit   = m_valid[l] && (m_tag[l] == a[31:10]);
  endtask

  // One command cycle: drive on the falling edge, capture on the rising edge.
  task automatic do_cmd(input logic [31:0] a, input logic s, input logic e,
                        input logic inv, input logic [31:0] d);
    @(negedge clk);
    addr = a; store = s; edit = e; invalid = inv; din = d;
    @(posedge clk);
    model_apply(a, s, e, inv, d);
    #1;
    store = 1'b0; edit = 1'b0; invalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; addr = '0; store = 1'b0; edit = 1'b0; invalid = 1'b0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    addr = 32'h0000_1234;
    #1;
    checks += 5;
    if (hit !== 1'b0)   begin errors++; $display("FAIL reset_hit: got %b expected 0", hit); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    if (dirty !== 1'b0) begin errors++; $display("FAIL reset_dirty: got %b expected 0", dirty); end
    if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
    if (tag !== 22'h0)  begin errors++; $display("FAIL reset_tag: got %h expected 0", tag); end
  endtask

  task automatic test_refill();
    for (int k = 0; k < 4; k++) begin
      do_cmd(32'h0000_1230 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 32'h0000_00A0 + 32'(k));
    end
    addr = 32'h0000_1238;
    #1;
    checks += 5;
    if (hit !== 1'b1)           begin errors++; $display("FAIL refill_hit: got %b expected 1", hit); end
    if (dout !== 32'h0000_00A2) begin errors++; $display("FAIL refill_dout: got %h expected 000000a2", dout); end
    if (dirty !== 1'b0)         begin errors++; $display("FAIL refill_dirty: got %b expected 0", dirty); end
    if (valid !== 1'b1)         begin errors++; $display("FAIL refill_valid: got %b expected 1", valid); end
    if (tag !== 22'h000004)     begin errors++; $display("FAIL refill_tag: got %h expected 000004", tag); end
    for (int k = 0; k < 4; k++) begin
      addr = 32'h0000_1230 + 32'(4 * k);
      #1;
      checks++;
      if (dout !== 32'h0000_00A0 + 32'(k)) begin
        errors++;
        $display("FAIL refill_word%0d: got %h expected %h", k, dout, 32'h0000_00A0 + 32'(k));
      end
    end
  endtask

  task automatic test_edit();
    @(negedge clk);
    addr = 32'h0000_1234; edit = 1'b1; din = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (dout !== 32'h0000_00A1) begin errors++; $display("FAIL edit_no_bypass: got %h expected 000000a1", dout); end
    @(posedge clk);
    model_apply(32'h0000_1234, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    #1;
    edit = 1'b0;
    checks += 3;
    if (dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL edit_dout: got %h expected deadbeef", dout); end
    if (dirty !== DIRTY_EN)     begin errors++; $display("FAIL edit_dirty: got %b expected %b", dirty, DIRTY_EN); end
    if (hit !== 1'b1)           begin errors++; $display("FAIL edit_hit: got %b expected 1", hit); end
    addr = 32'h0000_1230;
    #1;
    checks++;
    if (dout !== 32'h0000_00A0) begin errors++; $display("FAIL edit_neighbour: got %h expected 000000a0", dout); end
  endtask

  task automatic test_conflict();
    addr = 32'h0000_1634;
    #1;
    checks += 4;
    if (hit !== 1'b0)       begin errors++; $display("FAIL conflict_hit: got %b expected 0", hit); end
    if (valid !== 1'b1)     begin errors++; $display("FAIL conflict_valid: got %b expected 1", valid); end
    if (dirty !== DIRTY_EN) begin errors++; $display("FAIL conflict_dirty: got %b expected %b", dirty, DIRTY_EN); end
    if (tag !== 22'h000004) begin errors++; $display("FAIL conflict_tag: got %h expected 000004", tag); end
  endtask

  task automatic test_invalid_priority();
    do_cmd(32'h0000_1230, 1'b1, 1'b1, 1'b1, 32'h5555_5555);
    addr = 32'h0000_1230;
    #1;
    checks += 5;
    if (valid !== 1'b0)         begin errors++; $display("FAIL inval_valid: got %b expected 0", valid); end
    if (dirty !== 1'b0)         begin errors++; $display("FAIL inval_dirty: got %b expected 0", dirty); end
    if (hit !== 1'b0)           begin errors++; $display("FAIL inval_hit: got %b expected 0", hit); end
    if (dout !== 32'h0000_00A0) begin errors++; $display("FAIL inval_dout: got %h expected 000000a0", dout); end
    if (tag !== 22'h000004)     begin errors++; $display("FAIL inval_tag: got %h expected 000004", tag); end
  endtask

  // Randomized back-to-back commands over a small address space so that
  // hits, conflicts and multi-command cycles are all frequent.
  task automatic test_back_to_back();
    logic [21:0] t;
    logic [5:0]  ix;
    logic [1:0]  w;
    logic [1:0]  b;
    logic [31:0] a;
    logic        e_hit, e_valid, e_dirty;
    logic [31:0] e_dout;
    logic [21:0] e_tag;
    for (int n = 0; n < 300; n++) begin
      t  = 22'($urandom_range(0, 2));
      ix = 6'($urandom_range(0, 7));
      w  = 2'($urandom_range(0, 3));
      b  = 2'($urandom_range(0, 3));
      a  = {t, ix, w, b};
      do_cmd(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 5) == 0), $urandom);
      t  = 22'($urandom_range(0, 2));
      ix = 6'($urandom_range(0, 7));
      w  = 2'($urandom_range(0, 3));
      addr = (n % 2 == 0) ? a : {t, ix, w, 2'b00};
      #1;
      model_read(addr, e_hit, e_dout, e_valid, e_dirty, e_tag);
      checks += 5;
      if (hit !== e_hit)     begin errors++; $display("FAIL rand_hit @%h: got %b expected %b", addr, hit, e_hit); end
      if (dout !== e_dout)   begin errors++; $display("FAIL rand_dout @%h: got %h expected %h", addr, dout, e_dout); end
      if (valid !== e_valid) begin errors++; $display("FAIL rand_valid @%h: got %b expected %b", addr, valid, e_valid); end
      if (dirty !== e_dirty) begin errors++; $display("FAIL rand_dirty @%h: got %b expected %b", addr, dirty, e_dirty); end
      if (tag !== e_tag)     begin errors++; $display("FAIL rand_tag @%h: got %h expected %h", addr, tag, e_tag); end
    end
  endtask

  task automatic test_async_reset();
    do_cmd(32'h0000_1238, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    addr = 32'h0000_1238;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks += 5;
    if (hit !== 1'b0)   begin errors++; $display("FAIL areset_hit: got %b expected 0", hit); end
    if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", valid); end
    if (dirty !== 1'b0) begin errors++; $display("FAIL areset_dirty: got %b expected 0", dirty); end
    if (dout !== 32'h0) begin errors++; $display("FAIL areset_dout: got %h expected 0", dout); end
    if (tag !== 22'h0)  begin errors++; $display("FAIL areset_tag: got %h expected 0", tag); end
    // A command held across an edge during reset must not take effect.
    store = 1'b1; din = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    store = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    checks += 2;
    if (valid !== 1'b0) begin errors++; $display("FAIL areset_cmd_valid: got %b expected 0", valid); end
    if (dout !== 32'h0) begin errors++; $display("FAIL areset_cmd_dout: got %h expected 0", dout); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_refill();
    test_edit();
    test_conflict();
    test_invalid_priority();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
